laser_scan_ctrl: RTL and testbench

Search scheduler for the two-circle LASER coverage engine. After the 40 target points are loaded, it raster-scans all 256 grid candidates for one circle center while the other center is held fixed. It hands each candidate to the shared coverage-count datapath over a valid/ready handshake and keeps the best result. It alternates between the two circles until a full pass gives no improvement or a pass limit is reached, then publishes C1/C2 and pulses DONE.

---
 rtl/laser_pkg.sv | 29 ++
 rtl/laser_cand_gen.sv | 56 +++++
 rtl/laser_scan_ctrl.sv | 172 +++++++++++++++++
 tb/tb_laser_scan_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared types and constants for the two-circle LASER coverage engine.
package laser_pkg;

    localparam int NPTS    = 40;   // number of target points held by the loader
    localparam int CNT_W   = 6;    // width of a coverage count (0..NPTS)
    localparam int COORD_W = 4;    // width of one grid coordinate

    localparam logic [COORD_W-1:0] GRID_MAX = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_FINISH
    } scan_state_e;

    // Which circle center is being optimized in the current phase.
    typedef enum logic {
        PH_C1 = 1'b0,
        PH_C2 = 1'b1
    } phase_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } coord_t;

endpackage

// File: rtl/laser_cand_gen.sv
// Raster scan position generator: walks x then y over the 16x16 grid and
// flags the last grid cell so the scheduler knows the phase is ending.
module laser_cand_gen
    import laser_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               clear_i,
    input  logic               adv_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               phase_end_o
);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               end_q, end_d;

    // Next scan position; the end flag is precomputed so it is a clean register.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        end_d = end_q;
        if (clear_i) begin
            x_d   = '0;
            y_d   = '0;
            end_d = 1'b0;
        end else if (adv_i) begin
            if (x_q == GRID_MAX) begin
                x_d = '0;
                y_d = y_q + 4'd1;   // (15,15) wraps naturally to (0,0)
            end else begin
                x_d = x_q + 4'd1;
            end
            end_d = (x_d == GRID_MAX) && (y_d == GRID_MAX);
        end
    end

    // Position and end-flag registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            x_q   <= '0;
            y_q   <= '0;
            end_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            end_q <= end_d;
        end
    end

    assign x_o         = x_q;
    assign y_o         = y_q;
    assign phase_end_o = end_q;

endmodule

// File: rtl/laser_scan_ctrl.sv
// Search scheduler: alternately raster-scans candidate centers for circle 1
// and circle 2, sends each to the coverage datapath, keeps the best pair and
// publishes it once a full pass brings no gain or the pass limit is hit.
module laser_scan_ctrl
    import laser_pkg::*;
#(
    parameter int                 MAX_PASS = 4,
    parameter logic [COORD_W-1:0] INIT_X   = 4'd0,
    parameter logic [COORD_W-1:0] INIT_Y   = 4'd0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    output logic               cand_valid,
    input  logic               cand_ready,
    output logic [COORD_W-1:0] cand_x,
    output logic [COORD_W-1:0] cand_y,
    output logic [COORD_W-1:0] fix_x,
    output logic [COORD_W-1:0] fix_y,
    input  logic               res_valid,
    input  logic [CNT_W-1:0]   res_cnt,
    output logic [COORD_W-1:0] C1X,
    output logic [COORD_W-1:0] C1Y,
    output logic [COORD_W-1:0] C2X,
    output logic [COORD_W-1:0] C2Y,
    output logic               DONE
);

    localparam logic [3:0] PASS_LIMIT = 4'(MAX_PASS);

    scan_state_e        state_q, state_d;
    phase_e             phase_q, phase_d;
    logic [3:0]         pass_q, pass_d;
    logic               improved_q, improved_d;
    logic [CNT_W-1:0]   best_q, best_d;
    coord_t             c1_q, c1_d, c2_q, c2_d;
    coord_t             c1_out_q, c1_out_d, c2_out_q, c2_out_d;
    logic               done_q, done_d;

    logic               gen_clear, gen_adv, gen_end;
    logic [COORD_W-1:0] scan_x, scan_y;
    logic               search_over;

    laser_cand_gen u_cand_gen (
        .CLK         (CLK),
        .RST         (RST),
        .clear_i     (gen_clear),
        .adv_i       (gen_adv),
        .x_o         (scan_x),
        .y_o         (scan_y),
        .phase_end_o (gen_end)
    );

    // Last cell of a C2 phase ends the search unless that pass improved and passes remain.
    assign search_over = gen_end && (phase_q == PH_C2) &&
                         (!improved_q || (pass_q == PASS_LIMIT));

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)      state_d = ST_ISSUE;
            ST_ISSUE:  if (cand_ready) state_d = ST_WAIT;
            ST_WAIT:   if (res_valid)  state_d = ST_NEXT;
            ST_NEXT:   state_d = search_over ? ST_FINISH : ST_ISSUE;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshake, candidate/fixed center, scan control, completion.
    always_comb begin
        cand_valid = (state_q == ST_ISSUE);
        cand_x     = scan_x;
        cand_y     = scan_y;
        fix_x      = (phase_q == PH_C1) ? c2_q.x : c1_q.x;
        fix_y      = (phase_q == PH_C1) ? c2_q.y : c1_q.y;
        gen_clear  = (state_q == ST_IDLE) && start;
        gen_adv    = (state_q == ST_NEXT);
        done_d     = (state_d == ST_FINISH);
    end

    // Search bookkeeping: centers, best count, phase, pass and improvement flag.
    always_comb begin
        phase_d    = phase_q;
        pass_d     = pass_q;
        improved_d = improved_q;
        best_d     = best_q;
        c1_d       = c1_q;
        c2_d       = c2_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    c1_d       = '{x: INIT_X, y: INIT_Y};
                    c2_d       = '{x: INIT_X, y: INIT_Y};
                    best_d     = '0;
                    phase_d    = PH_C1;
                    pass_d     = 4'd1;
                    improved_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // Strict compare so ties keep the earlier candidate.
                if (res_valid && (res_cnt > best_q)) begin
                    best_d     = res_cnt;
                    improved_d = 1'b1;
                    if (phase_q == PH_C1) begin
                        c1_d = '{x: scan_x, y: scan_y};
                    end else begin
                        c2_d = '{x: scan_x, y: scan_y};
                    end
                end
            end
            ST_NEXT: begin
                if (gen_end && !search_over) begin
                    if (phase_q == PH_C1) begin
                        phase_d = PH_C2;
                    end else begin
                        phase_d    = PH_C1;
                        pass_d     = pass_q + 4'd1;
                        improved_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        // Published centers move only on entry to FINISH, so they line up with DONE.
        c1_out_d = done_d ? c1_q : c1_out_q;
        c2_out_d = done_d ? c2_q : c2_out_q;
    end

    // Search bookkeeping and result registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            phase_q    <= PH_C1;
            pass_q     <= '0;
            improved_q <= 1'b0;
            best_q     <= '0;
            c1_q       <= '0;
            c2_q       <= '0;
            c1_out_q   <= '0;
            c2_out_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            pass_q     <= pass_d;
            improved_q <= improved_d;
            best_q     <= best_d;
            c1_q       <= c1_d;
            c2_q       <= c2_d;
            c1_out_q   <= c1_out_d;
            c2_out_q   <= c2_out_d;
            done_q     <= done_d;
        end
    end

    assign C1X  = c1_out_q.x;
    assign C1Y  = c1_out_q.y;
    assign C2X  = c2_out_q.x;
    assign C2Y  = c2_out_q.y;
    assign DONE = done_q;

endmodule

// File: tb/tb_laser_scan_ctrl.sv
// Directed bench for laser_scan_ctrl: a small coverage-datapath model answers
// each accepted candidate; two instances cover the default and a 2-pass limit.
module tb_laser_scan_ctrl;

    localparam int RUN_LIMIT = 8000;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       cand_ready = 1'b1;
    logic       res_valid = 1'b0;
    logic [5:0] res_cnt = 6'd0;
    logic       dut_sel = 1'b0;

    logic       start0, start1;
    logic       cv0, cv1, dn0, dn1;
    logic [3:0] cx0, cy0, fx0, fy0, c1x0, c1y0, c2x0, c2y0;
    logic [3:0] cx1, cy1, fx1, fy1, c1x1, c1y1, c2x1, c2y1;

    logic       cand_valid, DONE;
    logic [3:0] cand_x, cand_y, fix_x, fix_y, C1X, C1Y, C2X, C2Y;

    int n_assert = 0;
    int n_fail   = 0;
    int acc_n;
    bit done_seen;

    always #5 CLK = ~CLK;

    assign start0 = start & ~dut_sel;
    assign start1 = start &  dut_sel;

    assign cand_valid = dut_sel ? cv1  : cv0;
    assign DONE       = dut_sel ? dn1  : dn0;
    assign cand_x     = dut_sel ? cx1  : cx0;
    assign cand_y     = dut_sel ? cy1  : cy0;
    assign fix_x      = dut_sel ? fx1  : fx0;
    assign fix_y      = dut_sel ? fy1  : fy0;
    assign C1X        = dut_sel ? c1x1 : c1x0;
    assign C1Y        = dut_sel ? c1y1 : c1y0;
    assign C2X        = dut_sel ? c2x1 : c2x0;
    assign C2Y        = dut_sel ? c2y1 : c2y0;

    laser_scan_ctrl u_dut (
        .CLK(CLK), .RST(RST), .start(start0),
        .cand_valid(cv0), .cand_ready(cand_ready),
        .cand_x(cx0), .cand_y(cy0), .fix_x(fx0), .fix_y(fy0),
        .res_valid(res_valid), .res_cnt(res_cnt),
        .C1X(c1x0), .C1Y(c1y0), .C2X(c2x0), .C2Y(c2y0), .DONE(dn0)
    );

    laser_scan_ctrl #(.MAX_PASS(2)) u_dut_mp2 (
        .CLK(CLK), .RST(RST), .start(start1),
        .cand_valid(cv1), .cand_ready(cand_ready),
        .cand_x(cx1), .cand_y(cy1), .fix_x(fx1), .fix_y(fy1),
        .res_valid(res_valid), .res_cnt(res_cnt),
        .C1X(c1x1), .C1Y(c1y1), .C2X(c2x1), .C2Y(c2y1), .DONE(dn1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: constant 5; mode 1: targets (9,4)/(3,12) with ties; mode 2: gain once per phase
    task automatic run_search(input int mode, input bit sel, input bit stall_en,
                              input bit noise_en, input int abort_at);
        int cyc, ph, idx, stall_left, order_bad, hold_bad;
        logic [3:0]  ex, ey;
        logic [7:0]  efix, cxy, fxy;
        logic [15:0] held;
        bit          pend;
        logic [5:0]  pval;
        dut_sel = sel;
        acc_n = 0; done_seen = 0; ex = 4'd0; ey = 4'd0; pend = 0; pval = 6'd0;
        stall_left = 5; order_bad = 0; hold_bad = 0; cyc = 0;
        @(negedge CLK);
        held  = {C1X, C1Y, C2X, C2Y};
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("start_latency", {31'd0, cand_valid}, 32'd1);
        while (!done_seen && cyc < RUN_LIMIT) begin
            res_valid = 1'b0; start = 1'b0; cand_ready = 1'b1;
            if (DONE) begin
                done_seen = 1;
            end else begin
                if ({C1X, C1Y, C2X, C2Y} !== held) hold_bad++;
                if (pend) begin
                    res_valid = 1'b1; res_cnt = pval; pend = 0;
                end else if (cand_valid) begin
                    if (stall_en && acc_n == 7 && stall_left > 0) begin
                        cand_ready = 1'b0;
                        stall_left--;
                        chk("stall_hold", {cand_valid, cand_x, cand_y, fix_x, fix_y},
                            {1'b1, 4'd7, 4'd0, 4'd0, 4'd0});
                    end else begin
                        ph  = acc_n / 256;
                        idx = acc_n % 256;
                        cxy = {cand_x, cand_y};
                        fxy = {fix_x, fix_y};
                        if (cand_x !== ex || cand_y !== ey) order_bad++;
                        if (mode == 1) begin
                            case (ph)
                                0:       efix = 8'h00;
                                2:       efix = 8'h3C;
                                default: efix = 8'h94;
                            endcase
                            if (fxy !== efix) order_bad++;
                        end
                        case (mode)
                            0: pval = 6'd5;
                            1: begin
                                if (ph % 2 == 0 && (cxy == 8'h94 || cxy == 8'h5A))
                                    pval = 6'd30;
                                else if (ph % 2 == 1 && fxy == 8'h94 &&
                                         (cxy == 8'h3C || cxy == 8'hEE))
                                    pval = 6'd38;
                                else
                                    pval = 6'd0;
                            end
                            default: pval = (idx == ph) ? 6'(ph + 1) : 6'd0;
                        endcase
                        pend = 1;
                        if (noise_en && (acc_n % 13 == 5)) begin
                            res_valid = 1'b1; res_cnt = 6'd63; start = 1'b1;
                        end
                        acc_n++;
                        if (ex == 4'd15) begin ex = 4'd0; ey = ey + 4'd1; end
                        else ex = ex + 4'd1;
                        if (abort_at > 0 && acc_n == abort_at) break;
                    end
                end
            end
            if (!done_seen) begin
                @(negedge CLK);
                cyc++;
            end
        end
        chk("scan_order", order_bad, 0);
        chk("outputs_hold", hold_bad, 0);
    endtask

    task automatic post_run(input string tag, input int exp_acc, input logic [15:0] exp_res);
        chk({tag, "_done"}, {31'd0, done_seen}, 32'd1);
        chk({tag, "_accepts"}, acc_n, exp_acc);
        chk({tag, "_centers"}, {C1X, C1Y, C2X, C2Y}, exp_res);
        @(negedge CLK);
        res_valid = 1'b0; start = 1'b0;
        chk({tag, "_done_pulse"}, {DONE, cand_valid, C1X, C1Y, C2X, C2Y}, {2'b00, exp_res});
        $display("run %s: accepts=%0d C1=(%0d,%0d) C2=(%0d,%0d)",
                 tag, acc_n, C1X, C1Y, C2X, C2Y);
    endtask

    initial begin
        int quiet_bad;
        // Reset state on both instances.
        repeat (3) @(negedge CLK);
        dut_sel = 1'b0;
        chk("reset_outputs", {DONE, cand_valid, cand_x, cand_y, fix_x, fix_y, C1X, C1Y, C2X, C2Y}, 0);
        dut_sel = 1'b1;
        #1;
        chk("reset_outputs_mp2", {DONE, cand_valid, cand_x, cand_y, fix_x, fix_y, C1X, C1Y, C2X, C2Y}, 0);
        dut_sel = 1'b0;
        RST = 1'b0;

        // Spurious result strobe in IDLE is ignored.
        @(negedge CLK);
        res_valid = 1'b1; res_cnt = 6'd63;
        @(negedge CLK);
        res_valid = 1'b0;
        chk("idle_spurious_res", {DONE, cand_valid}, 2'b00);
        @(negedge CLK);
        chk("idle_stays_idle", {DONE, cand_valid}, 2'b00);

        // Constant 5: gain in pass 1 only, second pass flat.
        run_search(0, 1'b0, 1'b0, 1'b0, 0);
        post_run("const5", 1024, 16'h0000);

        // Targets: C1 -> (9,4), C2 -> (3,12); equal counts later do not move centers.
        run_search(1, 1'b0, 1'b0, 1'b0, 0);
        post_run("targets", 1024, 16'h943C);

        // Reset while waiting for a result in pass 1.
        run_search(0, 1'b0, 1'b0, 1'b0, 10);
        res_valid = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_async_valid", {DONE, cand_valid}, 2'b00);
        chk("rst_async_outputs", {cand_x, cand_y, fix_x, fix_y, C1X, C1Y, C2X, C2Y}, 0);
        @(negedge CLK);
        chk("rst_next_cycle", {DONE, cand_valid, cand_x, cand_y, C1X, C1Y, C2X, C2Y}, 0);
        @(negedge CLK);
        RST = 1'b0;
        quiet_bad = 0;
        repeat (20) begin
            @(negedge CLK);
            if (DONE !== 1'b0 || cand_valid !== 1'b0) quiet_bad++;
        end
        chk("rst_no_done", quiet_bad, 0);

        // Restart after reset, with a 5-cycle ready stall at candidate (7,0).
        run_search(0, 1'b0, 1'b1, 1'b0, 0);
        post_run("stall", 1024, 16'h0000);

        // Ever-improving model hits the pass limit: 2 passes, then 4 passes.
        run_search(2, 1'b1, 1'b0, 1'b0, 0);
        post_run("limit2", 1024, 16'h2030);
        run_search(2, 1'b0, 1'b0, 1'b0, 0);
        post_run("limit4", 2048, 16'h6070);

        // Spurious res_valid in ISSUE and start pulses mid-search change nothing.
        run_search(1, 1'b0, 1'b0, 1'b1, 0);
        post_run("noise", 1024, 16'h943C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
